btn_key_encoder: RTL and testbench

Converts the 25-bit key-state vector from the matrix keyboard scanner into a stream of discrete key events, one per key press or release. The block queues the events in a small FIFO for the CPU-side peripheral interface. It sits directly downstream of the button matrix scanner, which drives `btn_state` from its `result` output, and upstream of the MMIO keyboard register. The block compares each scan snapshot against its last acknowledged state and serializes every changed bit into an event.

---
 rtl/btn_key_encoder.sv | 135 +++++++++++++
 tb/tb_btn_key_encoder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/btn_key_encoder.sv
// Turns 25-bit scanner snapshots into press/release events queued in a fall-through FIFO.
// One event per cycle, visible the cycle after the change; a full queue drops the event and sets overflow, so the block never stalls.

module btn_key_fifo #(
    parameter int WIDTH   = 6,
    parameter int DEPTH   = 8,
    parameter int LEVEL_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_vld,
    input  logic [WIDTH-1:0]   push_dat,
    output logic               push_rdy,
    output logic               pop_vld,
    output logic [WIDTH-1:0]   pop_dat,
    input  logic               pop_rdy,
    output logic [LEVEL_W-1:0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [LEVEL_W-1:0] FULL_LVL = LEVEL_W'(DEPTH);

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [AW-1:0]      rd_ptr;
    logic [AW-1:0]      wr_ptr;
    logic [LEVEL_W-1:0] count;
    logic               push_acc;
    logic               pop_acc;

    assign pop_vld  = (count != '0);
    assign pop_acc  = pop_vld && pop_rdy;
    // A pop frees the slot being written this cycle, so full+pop still accepts.
    assign push_rdy = (count != FULL_LVL) || pop_acc;
    assign push_acc = push_vld && push_rdy;
    assign pop_dat  = pop_vld ? mem[rd_ptr] : '0;
    assign level    = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_acc) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_acc, pop_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module btn_key_encoder #(
    parameter int FIFO_DEPTH = 8,
    parameter int LEVEL_W    = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [24:0]        btn_state,
    output logic               key_valid,
    output logic [4:0]         key_code,
    output logic               key_press,
    input  logic               key_ready,
    output logic [LEVEL_W-1:0] fifo_level,
    output logic               overflow,
    input  logic               ovf_clr
);
    logic [24:0] ack_state;
    logic [24:0] diff;
    logic        sel_vld;
    logic [4:0]  sel_idx;
    logic        sel_press;
    logic        push_rdy;
    logic        drop;
    logic [5:0]  head_dat;

    // Lowest changed bit wins; the descending loop leaves the lowest index last.
    always_comb begin
        diff      = btn_state ^ ack_state;
        sel_vld   = 1'b0;
        sel_idx   = '0;
        sel_press = 1'b0;
        for (int i = 24; i >= 0; i--) begin
            if (diff[i]) begin
                sel_vld   = 1'b1;
                sel_idx   = 5'(i);
                sel_press = btn_state[i];
            end
        end
    end

    assign drop = sel_vld && !push_rdy;

    btn_key_fifo #(
        .WIDTH   (6),
        .DEPTH   (FIFO_DEPTH),
        .LEVEL_W (LEVEL_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (sel_vld),
        .push_dat ({sel_press, sel_idx}),
        .push_rdy (push_rdy),
        .pop_vld  (key_valid),
        .pop_dat  (head_dat),
        .pop_rdy  (key_ready),
        .level    (fifo_level)
    );

    assign key_press = head_dat[5];
    assign key_code  = head_dat[4:0];

    // The selected bit is acknowledged whether queued or dropped, so the block never stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_state <= '0;
            overflow  <= 1'b0;
        end else begin
            if (sel_vld) begin
                ack_state[sel_idx] <= sel_press;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_btn_key_encoder.sv
// Directed bench for btn_key_encoder: vector table plus hand sequences for reset and throughput.
module tb_btn_key_encoder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [24:0] btn_state = '0;
    logic        key_valid;
    logic [4:0]  key_code;
    logic        key_press;
    logic        key_ready = 1'b0;
    logic [3:0]  fifo_level;
    logic        overflow;
    logic        ovf_clr = 1'b0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [24:0] btn;
        logic        rdy;
        logic        clr;
        logic        v;
        logic [4:0]  code;
        logic        press;
        logic [3:0]  lvl;
        logic        ovf;
    } vec_t;

    vec_t vecs[$];

    btn_key_encoder #(.FIFO_DEPTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_state  (btn_state),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_press  (key_press),
        .key_ready  (key_ready),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string tag, input int v, input int code, input int press,
                             input int lvl, input int ovf);
        check({tag, ".valid"}, int'(key_valid), v);
        check({tag, ".code"},  int'(key_code),  code);
        check({tag, ".press"}, int'(key_press), press);
        check({tag, ".level"}, int'(fifo_level), lvl);
        check({tag, ".ovf"},   int'(overflow),  ovf);
    endtask

    task automatic add(input int b, input int r, input int c, input int v, input int code,
                       input int p, input int lvl, input int o);
        vec_t e;
        e.btn   = 25'(b);
        e.rdy   = 1'(r);
        e.clr   = 1'(c);
        e.v     = 1'(v);
        e.code  = 5'(code);
        e.press = 1'(p);
        e.lvl   = 4'(lvl);
        e.ovf   = 1'(o);
        vecs.push_back(e);
    endtask

    initial begin
        int seen;
        // single press / release
        add(4, 0, 0, 1, 2, 1, 1, 0);
        add(4, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 2, 0, 1, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0);
        // three simultaneous presses serialized in ascending order
        for (int k = 1; k <= 3; k++) add(32'h1000011, 0, 0, 1, 0, 1, k, 0);
        add(32'h1000011, 0, 0, 1, 0, 1, 3, 0);
        add(32'h1000011, 1, 0, 1, 4, 1, 2, 0);
        add(32'h1000011, 1, 0, 1, 24, 1, 1, 0);
        add(32'h1000011, 1, 0, 0, 0, 0, 0, 0);
        // releases streamed with ready held high
        add(0, 1, 0, 1, 0, 0, 1, 0);
        add(0, 1, 0, 1, 4, 0, 1, 0);
        add(0, 1, 0, 1, 24, 0, 1, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0);
        // ten presses into a depth-8 queue: codes 8 and 9 dropped
        for (int k = 1; k <= 8; k++) add(32'h3FF, 0, 0, 1, 0, 1, k, 0);
        for (int k = 0; k < 3; k++)  add(32'h3FF, 0, 0, 1, 0, 1, 8, 1);
        for (int j = 1; j <= 7; j++) add(32'h3FF, 1, 0, 1, j, 1, 8 - j, 1);
        add(32'h3FF, 1, 0, 0, 0, 0, 0, 1);
        add(32'h3FF, 0, 1, 0, 0, 0, 0, 0);
        // full queue with a simultaneous pop accepts the new event
        for (int k = 1; k <= 8; k++) add(32'h3FFFF, 0, 0, 1, 10, 1, k, 0);
        add(32'h13FFFF, 1, 0, 1, 11, 1, 8, 0);
        add(32'h13FFFF, 0, 0, 1, 11, 1, 8, 0);
        for (int j = 1; j <= 6; j++) add(32'h13FFFF, 1, 0, 1, 11 + j, 1, 8 - j, 0);
        add(32'h13FFFF, 1, 0, 1, 20, 1, 1, 0);
        add(32'h13FFFF, 1, 0, 0, 0, 0, 0, 0);

        rst = 1'b1;
        step();
        step();
        check_out("reset", 0, 0, 0, 0, 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            btn_state = vecs[i].btn;
            key_ready = vecs[i].rdy;
            ovf_clr   = vecs[i].clr;
            step();
            check_out($sformatf("vec%0d", i), int'(vecs[i].v), int'(vecs[i].code),
                      int'(vecs[i].press), int'(vecs[i].lvl), int'(vecs[i].ovf));
        end
        key_ready = 1'b0;
        ovf_clr   = 1'b0;

        // keys held through reset produce presses right after release
        rst       = 1'b1;
        btn_state = 25'h0000003;
        step();
        check_out("held_rst", 0, 0, 0, 0, 0);
        rst = 1'b0;
        step();
        check_out("held_ev0", 1, 0, 1, 1, 0);
        step();
        check_out("held_ev1", 1, 0, 1, 2, 0);
        key_ready = 1'b1;
        step();
        check_out("held_pop0", 1, 1, 1, 1, 0);
        step();
        check_out("held_pop1", 0, 0, 0, 0, 0);
        key_ready = 1'b0;

        // reset discards queued events
        btn_state = 25'h000007F;
        for (int k = 0; k < 5; k++) step();
        check_out("q5", 1, 2, 1, 5, 0);
        rst = 1'b1;
        step();
        check_out("mid_rst", 0, 0, 0, 0, 0);
        btn_state = '0;
        step();
        rst = 1'b0;
        step();
        check_out("post_rst", 0, 0, 0, 0, 0);

        // 25 keys at once drained one per cycle with ready held high
        key_ready = 1'b1;
        btn_state = 25'h1FFFFFF;
        seen = 0;
        step();
        check_out("burst0", 1, 0, 1, 1, 0);
        if (key_valid) seen++;
        for (int j = 1; j < 25; j++) begin
            step();
            check_out($sformatf("burst%0d", j), 1, j, 1, 1, 0);
            if (key_valid) seen++;
        end
        step();
        check_out("burst_end", 0, 0, 0, 0, 0);
        check("burst_count", seen, 25);
        key_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
